// File: rtl/mod_dma_seq.sv
// rtl/mod_dma_seq.sv - DMA phase sequencer (idle/load/run/flush); irq built only with MOD_DMA_SEQ_IRQ_EN
module mod_dma_seq #(
  parameter int LEN_W     = 10,
  parameter int FLUSH_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len_load,
  input  logic [LEN_W-1:0] i_len_run,
  input  logic             i_abort,
  input  logic             i_irq_clr,
  output logic [1:0]       o_state,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [LEN_W-1:0] o_phase_cnt,
  output logic             o_irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_RUN   = 2'b10,
    S_FLUSH = 2'b11
  } state_t;

  localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);
  localparam logic [LEN_W-1:0] ZERO       = '0;
  localparam logic [3:0]       FLUSH_LAST = 4'(FLUSH_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_len_load;
  logic [LEN_W-1:0] r_len_run;
  logic [LEN_W-1:0] r_phase_cnt;
  logic [LEN_W-1:0] r_run_cnt;
  logic [3:0]       r_flush_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic [LEN_W-1:0] w_len_load_nxt;
  logic [LEN_W-1:0] w_len_run_nxt;
  logic [LEN_W-1:0] w_phase_nxt;
  logic [LEN_W-1:0] w_run_nxt;
  logic [3:0]       w_flush_nxt;
  logic             w_done_nxt;
  logic             w_aborted_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_len_load  <= '0;
      r_len_run   <= '0;
      r_phase_cnt <= '0;
      r_run_cnt   <= '0;
      r_flush_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len_load  <= w_len_load_nxt;
      r_len_run   <= w_len_run_nxt;
      r_phase_cnt <= w_phase_nxt;
      r_run_cnt   <= w_run_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
      r_aborted   <= w_aborted_nxt;
    end
  end

  // phase_cnt tracks the mod_dma address; the RUN length is timed by r_run_cnt so wrap is harmless
  always_comb begin
    w_state_nxt    = r_state;
    w_len_load_nxt = r_len_load;
    w_len_run_nxt  = r_len_run;
    w_phase_nxt    = r_phase_cnt;
    w_run_nxt      = r_run_cnt;
    w_flush_nxt    = r_flush_cnt;
    w_done_nxt     = 1'b0;
    w_aborted_nxt  = r_aborted;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_len_load_nxt = i_len_load;
          w_len_run_nxt  = i_len_run;
          w_aborted_nxt  = 1'b0;
          w_phase_nxt    = '0;
          w_run_nxt      = '0;
          w_flush_nxt    = '0;
          if (i_len_load != ZERO) begin
            w_state_nxt = S_LOAD;
          end else if (i_len_run != ZERO) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end
      end

      S_LOAD: begin
        if (i_abort) begin
          w_state_nxt   = S_FLUSH;
          w_phase_nxt   = '0;
          w_flush_nxt   = '0;
          w_aborted_nxt = 1'b1;
        end else if (r_phase_cnt == r_len_load - ONE) begin
          if (r_len_run != ZERO) begin
            w_state_nxt = S_RUN;
            w_run_nxt   = '0;
            w_phase_nxt = r_phase_cnt + ONE;
          end else begin
            w_state_nxt = S_FLUSH;
            w_phase_nxt = '0;
            w_flush_nxt = '0;
          end
        end else begin
          w_phase_nxt = r_phase_cnt + ONE;
        end
      end

      S_RUN: begin
        if (i_abort) begin
          w_state_nxt   = S_FLUSH;
          w_phase_nxt   = '0;
          w_flush_nxt   = '0;
          w_aborted_nxt = 1'b1;
        end else if (r_run_cnt == r_len_run - ONE) begin
          w_state_nxt = S_FLUSH;
          w_phase_nxt = '0;
          w_flush_nxt = '0;
        end else begin
          w_run_nxt   = r_run_cnt + ONE;
          w_phase_nxt = r_phase_cnt + ONE;
        end
      end

      S_FLUSH: begin
        if (r_flush_cnt == FLUSH_LAST) begin
          w_state_nxt = S_IDLE;
          w_flush_nxt = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_flush_nxt = r_flush_cnt + 4'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  assign o_state     = r_state;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_aborted   = r_aborted;
  assign o_phase_cnt = r_phase_cnt;

`ifdef MOD_DMA_SEQ_IRQ_EN
  logic r_irq;

  // irq rises the cycle after done; a clear arriving with done loses to the set
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq <= 1'b0;
    end else if (r_done) begin
      r_irq <= 1'b1;
    end else if (i_irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign o_irq = r_irq;
`else
  logic w_unused_irq_clr;
  assign w_unused_irq_clr = i_irq_clr;
  assign o_irq            = 1'b0;
`endif

endmodule

// File: tb/tb_mod_dma_seq.sv
// tb/tb_mod_dma_seq.sv - transfer-schedule model and directed checks for mod_dma_seq
module tb_mod_dma_seq;

  localparam int LEN_W     = 10;
  localparam int FLUSH_CYC = 2;
`ifdef MOD_DMA_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic             clk;
  logic             s_rst;
  logic             s_start;
  logic [LEN_W-1:0] s_len_load;
  logic [LEN_W-1:0] s_len_run;
  logic             s_abort;
  logic             s_irq_clr;
  logic [1:0]       o_state;
  logic             o_busy;
  logic             o_done;
  logic             o_aborted;
  logic [LEN_W-1:0] o_phase_cnt;
  logic             o_irq;

  mod_dma_seq #(.LEN_W(LEN_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .i_clk       (clk),
    .i_rst       (s_rst),
    .i_start     (s_start),
    .i_len_load  (s_len_load),
    .i_len_run   (s_len_run),
    .i_abort     (s_abort),
    .i_irq_clr   (s_irq_clr),
    .o_state     (o_state),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_aborted   (o_aborted),
    .o_phase_cnt (o_phase_cnt),
    .o_irq       (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  bit cmp_en    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: each accepted start expands into its full per-cycle output schedule
  typedef struct packed {
    logic [1:0]       st;
    logic [LEN_W-1:0] pc;
    logic             dn;
  } ent_t;

  ent_t mq[$];
  logic m_ab  = 1'b0;
  logic m_irq = 1'b0;

  function automatic ent_t front();
    ent_t e;
    e = '0;
    if (mq.size() != 0) e = mq[0];
    return e;
  endfunction

  task automatic push_flush_done();
    ent_t e;
    for (int f = 0; f < FLUSH_CYC; f++) begin
      e = '{st: 2'b11, pc: '0, dn: 1'b0};
      mq.push_back(e);
    end
    e = '{st: 2'b00, pc: '0, dn: 1'b1};
    mq.push_back(e);
  endtask

  initial begin
    ent_t cur;
    ent_t e;
    forever begin
      @(posedge clk);
      cur = front();
      if (s_rst) begin
        mq.delete();
        m_ab  = 1'b0;
        m_irq = 1'b0;
      end else begin
        if (mq.size() != 0) void'(mq.pop_front());
        if (cur.st == 2'b00 && s_start) begin
          mq.delete();
          for (int k = 0; k < int'(s_len_load); k++) begin
            e = '{st: 2'b01, pc: LEN_W'(k), dn: 1'b0};
            mq.push_back(e);
          end
          for (int j = 0; j < int'(s_len_run); j++) begin
            e = '{st: 2'b10, pc: LEN_W'(int'(s_len_load) + j), dn: 1'b0};
            mq.push_back(e);
          end
          push_flush_done();
          m_ab = 1'b0;
        end else if ((cur.st == 2'b01 || cur.st == 2'b10) && s_abort) begin
          mq.delete();
          push_flush_done();
          m_ab = 1'b1;
        end
        if (IRQ_EN && cur.dn) m_irq = 1'b1;
        else if (IRQ_EN && s_irq_clr) m_irq = 1'b0;
      end
    end
  end

  initial begin
    ent_t f;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        f = front();
        chk("cmp_state",     o_state,     f.st);
        chk("cmp_busy",      o_busy,      f.st != 2'b00);
        chk("cmp_done",      o_done,      f.dn);
        chk("cmp_phase_cnt", o_phase_cnt, f.pc);
        chk("cmp_aborted",   o_aborted,   m_ab);
        chk("cmp_irq",       o_irq,       m_irq);
      end
    end
  end

  logic [1:0]       tr_st [1100];
  logic [LEN_W-1:0] tr_pc [1100];
  logic             tr_dn [1100];
  logic             tr_ab [1100];
  logic             tr_bz [1100];
  logic             tr_irq[1100];

  int basic_st [10] = '{1, 1, 1, 1, 2, 2, 2, 3, 3, 0};
  int basic_pc [10] = '{0, 1, 2, 3, 4, 5, 6, 0, 0, 0};

  task automatic do_start(input int ll, input int lr, input logic ab);
    s_len_load = LEN_W'(ll);
    s_len_run  = LEN_W'(lr);
    s_start    = 1'b1;
    s_abort    = ab;
    @(negedge clk);
    s_start    = 1'b0;
    s_abort    = 1'b0;
  endtask

  // Called at the negedge of cycle 1; records cycles 1..n and drives events in chosen cycles
  task automatic trace(input int n, input int abort_at, input int start_at,
                       input int rst_at, input int clr_at);
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      tr_st[c]  = o_state;
      tr_pc[c]  = o_phase_cnt;
      tr_dn[c]  = o_done;
      tr_ab[c]  = o_aborted;
      tr_bz[c]  = o_busy;
      tr_irq[c] = o_irq;
      s_abort   = (c == abort_at);
      s_start   = (c == start_at);
      s_rst     = (c == rst_at);
      s_irq_clr = (c == clr_at);
    end
    @(negedge clk);
    s_abort   = 1'b0;
    s_start   = 1'b0;
    s_rst     = 1'b0;
    s_irq_clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!o_busy && !o_done) break;
      @(negedge clk);
    end
    chk("idle_timeout", {o_busy, o_done}, 2'b00);
  endtask

  initial begin
    int cnt;
    s_rst      = 1'b1;
    s_start    = 1'b0;
    s_abort    = 1'b0;
    s_irq_clr  = 1'b0;
    s_len_load = '0;
    s_len_run  = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_state", o_state, 2'b00);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_aborted", o_aborted, 1'b0);
    chk("rst_phase_cnt", o_phase_cnt, 0);
    chk("rst_irq", o_irq, 1'b0);
    s_rst = 1'b0;
    @(negedge clk);

    do_start(4, 3, 1'b0);
    trace(12, 0, 0, 0, 0);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("basic_state_c%0d", c), tr_st[c], basic_st[c-1]);
      chk($sformatf("basic_pc_c%0d", c), tr_pc[c], basic_pc[c-1]);
      chk($sformatf("basic_done_c%0d", c), tr_dn[c], c == 10);
    end
    chk("basic_busy_c10", tr_bz[10], 1'b0);
    chk("basic_irq_c11", tr_irq[11], IRQ_EN);
    s_irq_clr = 1'b1;
    @(negedge clk);
    s_irq_clr = 1'b0;
    chk("irq_clr", o_irq, 1'b0);

    do_start(0, 5, 1'b0);
    trace(9, 0, 0, 0, 0);
    chk("zl_state_c1", tr_st[1], 2'b10);
    chk("zl_pc_c5", tr_pc[5], 4);
    chk("zl_state_c6", tr_st[6], 2'b11);
    chk("zl_done_c8", tr_dn[8], 1'b1);
    chk("zl_done_c7", tr_dn[7], 1'b0);

    do_start(0, 0, 1'b0);
    trace(4, 0, 0, 0, 0);
    chk("zz_state_c1", tr_st[1], 2'b11);
    chk("zz_state_c2", tr_st[2], 2'b11);
    chk("zz_done_c3", tr_dn[3], 1'b1);

    do_start(8, 2, 1'b0);
    trace(8, 3, 0, 0, 0);
    chk("ab_pc_c3", tr_pc[3], 2);
    chk("ab_state_c4", tr_st[4], 2'b11);
    chk("ab_pc_c4", tr_pc[4], 0);
    chk("ab_aborted_c4", tr_ab[4], 1'b1);
    chk("ab_done_c5", tr_dn[5], 1'b0);
    chk("ab_done_c6", tr_dn[6], 1'b1);
    chk("ab_aborted_c8", tr_ab[8], 1'b1);
    do_start(1, 1, 1'b0);
    trace(6, 0, 0, 0, 0);
    chk("ab_cleared_c1", tr_ab[1], 1'b0);
    chk("short_done_c5", tr_dn[5], 1'b1);

    do_start(2, 3, 1'b0);
    trace(15, 0, 4, 0, 0);
    cnt = 0;
    for (int c = 1; c <= 15; c++) cnt += int'(tr_dn[c]);
    chk("busy_start_done_count", cnt, 1);
    chk("busy_start_done_c8", tr_dn[8], 1'b1);
    chk("busy_start_state_c12", tr_st[12], 2'b00);

    do_start(3, 1, 1'b1);
    trace(8, 0, 0, 0, 0);
    chk("sa_state_c4", tr_st[4], 2'b10);
    chk("sa_done_c7", tr_dn[7], 1'b1);
    chk("sa_aborted_c7", tr_ab[7], 1'b0);

    do_start(4, 3, 1'b0);
    trace(12, 0, 10, 0, 0);
    chk("restart_done_c10", tr_dn[10], 1'b1);
    chk("restart_state_c11", tr_st[11], 2'b01);
    chk("restart_pc_c11", tr_pc[11], 0);
    wait_idle(40);

    do_start(1, 0, 1'b0);
    trace(6, 0, 0, 0, 4);
    chk("irqwin_done_c4", tr_dn[4], 1'b1);
    chk("irqwin_irq_c5", tr_irq[5], IRQ_EN);
    chk("irqwin_irq_c6", tr_irq[6], IRQ_EN);

    do_start(2, 5, 1'b0);
    trace(12, 0, 0, 4, 0);
    chk("rst_run_state_c4", tr_st[4], 2'b10);
    chk("rst_run_state_c5", tr_st[5], 2'b00);
    chk("rst_run_pc_c5", tr_pc[5], 0);
    chk("rst_run_busy_c5", tr_bz[5], 1'b0);
    chk("rst_run_irq_c5", tr_irq[5], 1'b0);
    cnt = 0;
    for (int c = 5; c <= 12; c++) cnt += int'(tr_dn[c]);
    chk("rst_run_no_done", cnt, 0);

    do_start(1000, 30, 1'b0);
    trace(1040, 0, 0, 0, 0);
    chk("wrap_pc_c1000", tr_pc[1000], 999);
    chk("wrap_state_c1001", tr_st[1001], 2'b10);
    chk("wrap_pc_c1024", tr_pc[1024], 1023);
    chk("wrap_pc_c1025", tr_pc[1025], 0);
    chk("wrap_pc_c1030", tr_pc[1030], 5);
    chk("wrap_state_c1031", tr_st[1031], 2'b11);
    chk("wrap_done_c1033", tr_dn[1033], 1'b1);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
